// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants, active-area offsets and capture FSM encoding
// used by the VGA capture path and the display generator.
package vga_pkg;

    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;

    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX  = 10'd1023;
    localparam logic [CNT_W-1:0] H_OFFSET = 10'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_OFFSET = 10'(V_SYNC + V_BP);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE        = 2'd0;
    localparam state_t ST_WAIT_ACTIVE = 2'd1;
    localparam state_t ST_CAPTURE     = 2'd2;
    localparam state_t ST_DONE        = 2'd3;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + 10'd1;
        end
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Registers the sync inputs, detects their falling edges and keeps the
// horizontal/vertical position counters.
module vga_sync_counter
    import vga_pkg::*;
(
    input  logic             dclk,
    input  logic             clr,
    input  logic             hsync,
    input  logic             vsync,
    output logic             hfall,
    output logic             vfall,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount
);

    logic             hsync_r;
    logic             vsync_r;
    logic             hsync_d_r;
    logic             vsync_d_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] vcnt_r;

    // Input stage plus one-cycle history for edge detection
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hsync_r   <= 1'b1;
            vsync_r   <= 1'b1;
            hsync_d_r <= 1'b1;
            vsync_d_r <= 1'b1;
        end else begin
            hsync_r   <= hsync;
            vsync_r   <= vsync;
            hsync_d_r <= hsync_r;
            vsync_d_r <= vsync_r;
        end
    end

    assign hfall = hsync_d_r & ~hsync_r;
    assign vfall = vsync_d_r & ~vsync_r;

    // hcnt_r is already 1 after an edge so hcount reads 0 during the edge cycle
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hcnt_r <= CNT_MAX;
            vcnt_r <= CNT_MAX;
        end else begin
            if (hfall) begin
                hcnt_r <= 10'd1;
            end else begin
                hcnt_r <= sat_inc(hcnt_r);
            end
            if (vfall) begin
                vcnt_r <= 10'd0;
            end else if (hfall) begin
                vcnt_r <= sat_inc(vcnt_r);
            end else begin
                vcnt_r <= vcnt_r;
            end
        end
    end

    assign hcount = hfall ? 10'd0 : hcnt_r;
    assign vcount = vcnt_r;

endmodule

// File: rtl/vga_capture.sv
// Captures a small monochrome window from the top-left of a 640x480 VGA stream
// into a shadow buffer and publishes it as bmpOutput once the frame is complete.
module vga_capture
    import vga_pkg::*;
#(
    parameter int IMG_W = 9,
    parameter int IMG_H = 9
) (
    input  logic                     dclk,
    input  logic                     clr,
    input  logic                     hsync,
    input  logic                     vsync,
    input  logic [2:0]               red,
    input  logic [2:0]               green,
    input  logic [2:0]               blue,
    output logic [0:IMG_W*IMG_H-1]   bmpOutput,
    output logic                     frameValid,
    output logic                     syncError,
    output logic                     busy
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int IDX_W = $clog2(NPIX);

    logic             hfall;
    logic             vfall;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic [2:0]       red_r;
    logic [2:0]       green_r;
    logic [2:0]       blue_r;
    logic [0:NPIX-1]  shadow_r;
    logic [0:NPIX-1]  bmp_r;
    state_t           state_r;
    state_t           state_next_s;
    logic             frame_valid_r;
    logic             sync_error_r;
    logic             busy_r;
    logic             pix_s;
    logic             win_s;
    logic             origin_s;
    logic             last_s;
    logic             wr_s;
    logic             abort_s;
    int               px_x_s;
    int               px_y_s;
    logic [IDX_W-1:0] idx_s;

    vga_sync_counter u_sync (
        .dclk   (dclk),
        .clr    (clr),
        .hsync  (hsync),
        .vsync  (vsync),
        .hfall  (hfall),
        .vfall  (vfall),
        .hcount (hcount),
        .vcount (vcount)
    );

    // Colour half of the input stage, aligned with the registered syncs
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            red_r   <= 3'd0;
            green_r <= 3'd0;
            blue_r  <= 3'd0;
        end else begin
            red_r   <= red;
            green_r <= green;
            blue_r  <= blue;
        end
    end

    assign pix_s = |{red_r, green_r, blue_r};

    // Coordinates relative to the active-area origin; negative before it
    always_comb begin
        px_x_s   = int'(hcount) - int'(H_OFFSET);
        px_y_s   = int'(vcount) - int'(V_OFFSET);
        win_s    = (px_x_s >= 32'sd0) && (px_x_s < IMG_W) &&
                   (px_y_s >= 32'sd0) && (px_y_s < IMG_H);
        origin_s = (px_x_s == 32'sd0) && (px_y_s == 32'sd0);
        last_s   = (px_x_s == IMG_W - 1) && (px_y_s == IMG_H - 1);
        idx_s    = IDX_W'(px_y_s * IMG_W + px_x_s);
    end

    // Frame FSM; a vsync edge mid-frame always wins over a pixel write
    always_comb begin
        state_next_s = state_r;
        wr_s         = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (vfall) begin
                    state_next_s = ST_WAIT_ACTIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_ACTIVE: begin
                if (vfall) begin
                    abort_s      = 1'b1;
                    state_next_s = ST_WAIT_ACTIVE;
                end else if (origin_s) begin
                    wr_s         = 1'b1;
                    state_next_s = last_s ? ST_DONE : ST_CAPTURE;
                end else begin
                    state_next_s = ST_WAIT_ACTIVE;
                end
            end
            ST_CAPTURE: begin
                if (vfall) begin
                    abort_s      = 1'b1;
                    state_next_s = ST_WAIT_ACTIVE;
                end else if (win_s) begin
                    wr_s         = 1'b1;
                    state_next_s = last_s ? ST_DONE : ST_CAPTURE;
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // busy lags the state by one cycle so it drops together with frameValid
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_r       <= ST_IDLE;
            frame_valid_r <= 1'b0;
            sync_error_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            frame_valid_r <= (state_r == ST_DONE);
            sync_error_r  <= abort_s;
            busy_r        <= (state_r == ST_WAIT_ACTIVE) || (state_r == ST_CAPTURE);
        end
    end

    // Pixels land in the shadow buffer; bmpOutput only changes in DONE
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            shadow_r <= {NPIX{1'b0}};
            bmp_r    <= {NPIX{1'b0}};
        end else begin
            if (abort_s) begin
                shadow_r <= {NPIX{1'b0}};
            end else if (wr_s) begin
                shadow_r[idx_s] <= pix_s;
            end else begin
                shadow_r <= shadow_r;
            end
            if (state_r == ST_DONE) begin
                bmp_r <= shadow_r;
            end else begin
                bmp_r <= bmp_r;
            end
        end
    end

    assign bmpOutput  = bmp_r;
    assign frameValid = frame_valid_r;
    assign syncError  = sync_error_r;
    assign busy       = busy_r;

endmodule
